// File: rtl/mips_mc_control.sv
// Main control FSM for the multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Define MIPS_CTRL_PERF_EN to build the cycle/instruction performance counters.
module mips_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             inst_valid,
  input  logic             mem_ready,
  output logic [3:0]       current_state,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             valid,
  output logic             illegal,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic [3:0] state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign current_state = state_q;

  // Codes 12-15 fall into the default arm and recover to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = inst_valid ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    valid         = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = inst_valid;
        pc_write  = inst_valid;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J});
      end
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        i_or_d   = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        valid      = 1'b1;
      end
      S_MEMWR: begin
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        valid     = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        valid     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_source     = 2'b01;
        pc_write_cond = 1'b1;
        valid         = 1'b1;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        valid     = 1'b1;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        valid     = 1'b1;
      end
      default: ;
    endcase
    // Strobes must be dead the instant reset asserts, before the state register settles.
    if (!rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      valid         = 1'b0;
      illegal       = 1'b0;
    end
  end

`ifdef MIPS_CTRL_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (valid) instr_cnt_q <= instr_cnt_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized self-checking bench for mips_mc_control; expectations come from a
// per-instruction step model. Honours MIPS_CTRL_PERF_EN for the counter checks.
module tb_mips_mc_control;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       inst_valid;
  logic       mem_ready;
  logic [3:0] current_state;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, valid, illegal;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] cycle_cnt, instr_cnt;

`ifdef MIPS_CTRL_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       vld, ill;
  } ctrl_t;

  typedef enum {
    FetchIdle, FetchAccept, Decode, DecodeBad, MemAdr, MemRdWait, MemRdDone,
    MemWb, MemWrWait, MemWrDone, Exec, AluWb, Branch, AddiEx, AddiWb, Jump
  } step_e;

  int checks = 0;
  int errors = 0;
  int cycModel = 0;
  int instrModel = 0;

  mips_mc_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .inst_valid(inst_valid),
    .mem_ready(mem_ready), .current_state(current_state), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .valid(valid), .illegal(illegal), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ctrl_t observedCtrl();
    ctrl_t c;
    c = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
          reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, valid, illegal};
    return c;
  endfunction

  // Expected control word and state for one step of an instruction.
  function automatic ctrl_t ctrlOf(input step_e s, output logic [3:0] st);
    ctrl_t c;
    c = '0;
    st = 4'd0;
    case (s)
      FetchIdle:   begin c.mrd = 1; c.srcb = 2'b01; end
      FetchAccept: begin c.mrd = 1; c.srcb = 2'b01; c.irw = 1; c.pcw = 1; end
      Decode:      begin st = 4'd1; c.srcb = 2'b11; end
      DecodeBad:   begin st = 4'd1; c.srcb = 2'b11; c.ill = 1; end
      MemAdr:      begin st = 4'd2; c.srca = 1; c.srcb = 2'b10; end
      MemRdWait,
      MemRdDone:   begin st = 4'd3; c.iord = 1; c.mrd = 1; end
      MemWb:       begin st = 4'd4; c.m2r = 1; c.rw = 1; c.vld = 1; end
      MemWrWait:   begin st = 4'd5; c.iord = 1; c.mwr = 1; end
      MemWrDone:   begin st = 4'd5; c.iord = 1; c.mwr = 1; c.vld = 1; end
      Exec:        begin st = 4'd6; c.srca = 1; c.aluop = 2'b10; end
      AluWb:       begin st = 4'd7; c.rdst = 1; c.rw = 1; c.vld = 1; end
      Branch:      begin st = 4'd8; c.srca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01;
                         c.pcwc = 1; c.vld = 1; end
      AddiEx:      begin st = 4'd9; c.srca = 1; c.srcb = 2'b10; end
      AddiWb:      begin st = 4'd10; c.rw = 1; c.vld = 1; end
      Jump:        begin st = 4'd11; c.pcsrc = 2'b10; c.pcw = 1; c.vld = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] expCycles();
    return PerfEn ? 32'(cycModel % 16) : 32'd0;
  endfunction

  function automatic logic [31:0] expInstrs();
    return PerfEn ? 32'(instrModel % 16) : 32'd0;
  endfunction

  // Called just after a rising edge; checks mid-cycle and returns just after the next edge.
  task automatic applyStimulus(input step_e s, input logic iv, input logic mr);
    ctrl_t exp;
    logic [3:0] st;
    exp = ctrlOf(s, st);
    inst_valid = iv;
    mem_ready  = mr;
    @(negedge clk);
    checkOutput({s.name(), " state"}, 32'(current_state), 32'(st));
    checkOutput({s.name(), " ctrl"}, 32'(observedCtrl()), 32'(exp));
    checkOutput("cycle_cnt", 32'(cycle_cnt), expCycles());
    checkOutput("instr_cnt", 32'(instr_cnt), expInstrs());
    @(posedge clk);
    #1;
    cycModel++;
    if (exp.vld) instrModel++;
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic runInstr(input logic [5:0] op, input int idle, input int waits);
    for (int i = 0; i < idle; i++) begin
      opcode = 6'($urandom);
      applyStimulus(FetchIdle, 1'b0, rnd());
    end
    opcode = op;
    applyStimulus(FetchAccept, 1'b1, rnd());
    if (!(op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02})) begin
      applyStimulus(DecodeBad, rnd(), rnd());
      return;
    end
    applyStimulus(Decode, rnd(), rnd());
    case (op)
      6'h23: begin
        applyStimulus(MemAdr, rnd(), rnd());
        for (int i = 0; i < waits; i++) applyStimulus(MemRdWait, rnd(), 1'b0);
        applyStimulus(MemRdDone, rnd(), 1'b1);
        applyStimulus(MemWb, rnd(), rnd());
      end
      6'h2B: begin
        applyStimulus(MemAdr, rnd(), rnd());
        for (int i = 0; i < waits; i++) applyStimulus(MemWrWait, rnd(), 1'b0);
        applyStimulus(MemWrDone, rnd(), 1'b1);
      end
      6'h00: begin
        applyStimulus(Exec, rnd(), rnd());
        applyStimulus(AluWb, rnd(), rnd());
      end
      6'h04: applyStimulus(Branch, rnd(), rnd());
      6'h08: begin
        applyStimulus(AddiEx, rnd(), rnd());
        applyStimulus(AddiWb, rnd(), rnd());
      end
      default: applyStimulus(Jump, rnd(), rnd());
    endcase
  endtask

  task automatic checkResetState(input string tag);
    ctrl_t exp;
    exp = '0;
    exp.srcb = 2'b01;
    checkOutput({tag, " state"}, 32'(current_state), 32'd0);
    checkOutput({tag, " ctrl"}, 32'(observedCtrl()), 32'(exp));
    checkOutput({tag, " cycle_cnt"}, 32'(cycle_cnt), 32'd0);
    checkOutput({tag, " instr_cnt"}, 32'(instr_cnt), 32'd0);
  endtask

  task automatic resetAndRelease();
    rst = 1'b0;
    inst_valid = 1'b1;
    #2;
    checkResetState("reset");
    @(posedge clk);
    #1;
    checkResetState("reset held");
    cycModel = 0;
    instrModel = 0;
    rst = 1'b1;
  endtask

  initial begin
    logic [5:0] opTable [7];
    opTable = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h3F};
    rst = 1'b0;
    opcode = 6'h00;
    inst_valid = 1'b1;
    mem_ready = 1'b0;
    resetAndRelease();

    runInstr(6'h23, 0, 2);
    runInstr(6'h00, 0, 0);
    runInstr(6'h04, 0, 0);
    runInstr(6'h02, 0, 0);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h2B, 1, 0);

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = opTable[$urandom_range(0, 6)];
      if (op == 6'h3F) op = 6'($urandom_range(9, 34));
      runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset in the middle of a stalled store.
    opcode = 6'h2B;
    applyStimulus(FetchAccept, 1'b1, 1'b0);
    applyStimulus(Decode, 1'b0, 1'b0);
    applyStimulus(MemAdr, 1'b0, 1'b0);
    applyStimulus(MemWrWait, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #1;
    checkOutput("memwr before reset", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    checkResetState("mid-store reset");
    @(posedge clk);
    #1;
    checkResetState("mid-store reset held");
    inst_valid = 1'b0;
    cycModel = 0;
    instrModel = 0;
    rst = 1'b1;
    runInstr(6'h08, 3, 0);

    resetAndRelease();
    for (int n = 0; n < 20; n++) runInstr(6'h08, 0, 0);
    checkOutput("cycle_cnt after 20 addi", 32'(cycle_cnt), 32'd0);
    checkOutput("instr_cnt after 20 addi", 32'(instr_cnt), PerfEn ? 32'd4 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
